// File: rtl/blowfish_round_seq.sv
// blowfish_round_seq
//   Sequencer for one Blowfish block (16 Feistel rounds plus output whitening).
//   It uses an external P-array store and an external combinational F unit.
//   One round is done per clock, so a block needs 18 cycles from the accept
//   edge to out_valid.
//
//   Optional feature: define BF_SEQ_ABORT_EN to add the `abort` input. That
//   input cancels a block that is in flight.
//
// Ports
//   clk       clock; all state changes on the rising edge
//   rst       synchronous, active-high reset
//   abort     (BF_SEQ_ABORT_EN only) drop the block in progress, back to IDLE
//   in_valid  a block and mode are offered
//   in_ready  high only in IDLE
//   pt        input block {left[63:32], right[31:0]}
//   mode      0 = encrypt, 1 = decrypt; sampled at accept
//   p_idx     subkey index 0..17 sent to the P-array store (0 when idle)
//   p_val     P[p_idx], returned combinationally
//   f_in      operand for the F unit (0 outside ROUND)
//   f_out     F(f_in), returned combinationally
//   out_valid ct holds a finished block
//   out_ready consumer takes ct
//   ct        result block {left, right}
module blowfish_round_seq (
  input  logic        clk,
  input  logic        rst,
`ifdef BF_SEQ_ABORT_EN
  input  logic        abort,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] pt,
  input  logic        mode,
  output logic [4:0]  p_idx,
  input  logic [31:0] p_val,
  output logic [31:0] f_in,
  input  logic [31:0] f_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] ct
);

  typedef enum logic [2:0] {IDLE, ROUND, FIN_A, FIN_B, DONE} state_t;

  state_t      state;
  logic [31:0] l_half;
  logic [31:0] r_half;
  logic [31:0] ctr_r;
  logic        mode_r;
  logic [3:0]  rnd;
  logic        abort_hit;
  logic        busy;

`ifdef BF_SEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Abort only takes effect while the block is still being computed.
  assign busy = (state == ROUND) || (state == FIN_A) || (state == FIN_B);

  // Decrypt walks the P-array backwards. FIN_A and FIN_B fetch the two
  // whitening subkeys: 16/17 for encrypt, 1/0 for decrypt.
  always_comb begin
    p_idx = 5'd0;
    f_in  = 32'd0;
    case (state)
      ROUND: begin
        p_idx = mode_r ? (5'd17 - {1'b0, rnd}) : {1'b0, rnd};
        f_in  = l_half ^ p_val;
      end
      FIN_A:   p_idx = mode_r ? 5'd1 : 5'd16;
      FIN_B:   p_idx = mode_r ? 5'd0 : 5'd17;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      l_half    <= 32'd0;
      r_half    <= 32'd0;
      ctr_r     <= 32'd0;
      mode_r    <= 1'b0;
      rnd       <= 4'd0;
      ct        <= 64'd0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (abort_hit && busy) begin
      // ct keeps the previous result; the partial block is dropped.
      state    <= IDLE;
      in_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          l_half   <= pt[63:32];
          r_half   <= pt[31:0];
          mode_r   <= mode;
          rnd      <= 4'd0;
          in_ready <= 1'b0;
          state    <= ROUND;
        end
        ROUND: begin
          // Feistel round with the swap folded in:
          // new R = L^P, new L = R^F(L^P).
          r_half <= l_half ^ p_val;
          l_half <= r_half ^ f_out;
          if (rnd == 4'd15) state <= FIN_A;
          else              rnd   <= rnd + 4'd1;
        end
        FIN_A: begin
          // The held L is the pre-swap right half. Whiten it into ct's low word.
          ctr_r <= l_half ^ p_val;
          state <= FIN_B;
        end
        FIN_B: begin
          ct        <= {r_half ^ p_val, ctr_r};
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blowfish_round_seq.sv
// tb_blowfish_round_seq
//   Directed bench for blowfish_round_seq.
//   The bench builds the standard Blowfish P-array and S-boxes itself. It
//   generates the hex digits of pi with Machin's formula, then runs the key
//   expansion for the all-zero 8-byte key. The bench then acts as the
//   external P store and F unit.
//
//   Known-answer vector:
//     E(0000000000000000) = 4EF997456198DD78
//
//   Define BF_SEQ_ABORT_EN to include the abort case.
module tb_blowfish_round_seq;

  localparam int NL = 1046;  // 1 integer limb + 1042 table words + 3 guard limbs
  localparam logic [63:0] KAT_CT = 64'h4EF997456198DD78;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] pt;
  logic        mode;
  logic [4:0]  p_idx;
  logic [31:0] p_val;
  logic [31:0] f_in;
  logic [31:0] f_out;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] ct;
`ifdef BF_SEQ_ABORT_EN
  logic        abort;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] pw   [0:NL-1];
  logic [31:0] tm   [0:NL-1];
  logic [31:0] at   [0:NL-1];
  logic [31:0] pi_w [0:NL-1];
  logic [31:0] parr [0:17];
  logic [31:0] sbox [0:3][0:255];

  blowfish_round_seq dut (
    .clk(clk), .rst(rst),
`ifdef BF_SEQ_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .pt(pt), .mode(mode),
    .p_idx(p_idx), .p_val(p_val), .f_in(f_in), .f_out(f_out),
    .out_valid(out_valid), .out_ready(out_ready), .ct(ct)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bf_f(input logic [31:0] x);
    return ((sbox[0][x[31:24]] + sbox[1][x[23:16]]) ^ sbox[2][x[15:8]]) + sbox[3][x[7:0]];
  endfunction

  // External P store and F unit
  always_comb begin
    p_val = 32'h0;
    if (p_idx < 5'd18) p_val = parr[p_idx];
  end
  assign f_out = bf_f(f_in);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // at = atan(1/x) as a fixed-point number (limb 0 is the integer part)
  task automatic atan_inv(input longint unsigned x);
    longint unsigned rem, cur, q, d, s, c;
    bit nz;
    int k;
    for (int i = 0; i < NL; i++) pw[i] = 32'h0;
    pw[0] = 32'h1;
    rem = 0;
    for (int i = 0; i < NL; i++) begin
      cur = (rem << 32) | 64'(pw[i]); q = cur / x; rem = cur % x; pw[i] = q[31:0];
    end
    for (int i = 0; i < NL; i++) at[i] = pw[i];
    k  = 1;
    nz = 1'b1;
    while (nz) begin
      rem = 0; nz = 1'b0;
      for (int i = 0; i < NL; i++) begin
        cur = (rem << 32) | 64'(pw[i]); q = cur / (x * x); rem = cur % (x * x);
        pw[i] = q[31:0];
        if (q != 0) nz = 1'b1;
      end
      d = 64'(2 * k + 1);
      rem = 0;
      for (int i = 0; i < NL; i++) begin
        cur = (rem << 32) | 64'(pw[i]); q = cur / d; rem = cur % d; tm[i] = q[31:0];
      end
      c = 0;
      for (int i = NL - 1; i >= 0; i--) begin
        if (k % 2 == 1) begin
          s = 64'(at[i]) - 64'(tm[i]) - c; c = {63'b0, s[63]};
        end else begin
          s = 64'(at[i]) + 64'(tm[i]) + c; c = s >> 32;
        end
        at[i] = s[31:0];
      end
      k++;
    end
  endtask

  // pi = 16*atan(1/5) - 4*atan(1/239)
  task automatic build_pi();
    longint unsigned s, c;
    atan_inv(5);
    c = 0;
    for (int i = NL - 1; i >= 0; i--) begin
      s = 64'(at[i]) * 16 + c; pi_w[i] = s[31:0]; c = s >> 32;
    end
    atan_inv(239);
    c = 0;
    for (int i = NL - 1; i >= 0; i--) begin
      s = 64'(at[i]) * 4 + c; tm[i] = s[31:0]; c = s >> 32;
    end
    c = 0;
    for (int i = NL - 1; i >= 0; i--) begin
      s = 64'(pi_w[i]) - 64'(tm[i]) - c; c = {63'b0, s[63]}; pi_w[i] = s[31:0];
    end
  endtask

  task automatic bf_enc(inout logic [31:0] l, inout logic [31:0] r);
    logic [31:0] t;
    for (int i = 0; i < 16; i++) begin
      l = l ^ parr[i];
      r = r ^ bf_f(l);
      t = l; l = r; r = t;
    end
    t = l; l = r; r = t;
    r = r ^ parr[16];
    l = l ^ parr[17];
  endtask

  task automatic key_setup_zero();
    logic [31:0] l, r;
    for (int i = 0; i < 18; i++) parr[i] = pi_w[1 + i];
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 256; j++) sbox[b][j] = pi_w[19 + 256 * b + j];
    chk("pi_p0", {32'h0, parr[0]}, 64'h243F6A88);
    chk("pi_s0", {32'h0, sbox[0][0]}, 64'hD1310BA6);
    // XOR with the all-zero key leaves P unchanged.
    l = 32'h0; r = 32'h0;
    for (int i = 0; i < 9; i++) begin
      bf_enc(l, r); parr[2 * i] = l; parr[2 * i + 1] = r;
    end
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 128; j++) begin
        bf_enc(l, r); sbox[b][2 * j] = l; sbox[b][2 * j + 1] = r;
      end
    l = 32'h0; r = 32'h0;
    bf_enc(l, r);
    chk("model_kat", {l, r}, KAT_CT);
  endtask

  // Accept one block and watch the p_idx walk and the output timing. Then hold
  // DONE for `hold` cycles with in_valid asserted, and release it.
  task automatic run_block(input logic [63:0] blk, input logic md, input logic [63:0] exp,
                           input int hold, input string tag);
    int ir_hi, ov_early;
    logic [4:0] pexp;
    ir_hi = 0; ov_early = 0;
    @(negedge clk);
    chk({tag, "_idle_rdy"}, {63'b0, in_ready}, 64'd1);
    pt = blk; mode = md; in_valid = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) begin in_valid = 1'b0; pt = ~blk; mode = ~md; end
      pexp = md ? 5'(18 - k) : 5'(k - 1);
      chk($sformatf("%s_pidx%0d", tag, k), {59'b0, p_idx}, {59'b0, pexp});
      if (in_ready)  ir_hi++;
      if (out_valid) ov_early++;
    end
    chk({tag, "_rdy_busy"}, 64'(ir_hi), 64'd0);
    chk({tag, "_ov_early"}, 64'(ov_early), 64'd0);
    @(negedge clk);
    chk({tag, "_ov"}, {63'b0, out_valid}, 64'd1);
    chk({tag, "_ct"}, ct, exp);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; pt = {$urandom, $urandom}; mode = 1'b0;
      @(negedge clk);
      chk($sformatf("%s_hold_ov%0d", tag, h), {63'b0, out_valid}, 64'd1);
      chk($sformatf("%s_hold_ct%0d", tag, h), ct, exp);
      chk($sformatf("%s_hold_rdy%0d", tag, h), {63'b0, in_ready}, 64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_rel_ov"}, {63'b0, out_valid}, 64'd0);
    chk({tag, "_rel_rdy"}, {63'b0, in_ready}, 64'd1);
  endtask

  initial begin
    int ov;
    rst = 1'b1; in_valid = 1'b0; pt = 64'h0; mode = 1'b0; out_ready = 1'b0;
`ifdef BF_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    build_pi();
    key_setup_zero();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ov", {63'b0, out_valid}, 64'd0);
    chk("rst_ct", ct, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", {63'b0, in_ready}, 64'd1);
    chk("post_rst_pidx", {59'b0, p_idx}, 64'd0);
    chk("post_rst_fin", {32'b0, f_in}, 64'd0);

    run_block(64'h0, 1'b0, KAT_CT, 5, "enc");
    run_block(KAT_CT, 1'b1, 64'h0, 0, "dec");
    run_block(64'h0, 1'b0, KAT_CT, 0, "enc2");

    // Reset during round 7
    @(negedge clk);
    pt = 64'h0; mode = 1'b0; in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
    end
    chk("r7_pidx", {59'b0, p_idx}, 64'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("r7_rdy", {63'b0, in_ready}, 64'd1);
    chk("r7_ov", {63'b0, out_valid}, 64'd0);
    chk("r7_ct", ct, 64'd0);
    chk("r7_pidx_idle", {59'b0, p_idx}, 64'd0);
    ov = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    chk("r7_no_ov", 64'(ov), 64'd0);

    run_block(64'h0, 1'b0, KAT_CT, 0, "enc3");

`ifdef BF_SEQ_ABORT_EN
    // Abort in FIN_A of a decrypt; ct must keep the encrypt result.
    @(negedge clk);
    pt = KAT_CT; mode = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
    end
    chk("ab_pidx_fina", {59'b0, p_idx}, 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_rdy", {63'b0, in_ready}, 64'd1);
    chk("ab_ov", {63'b0, out_valid}, 64'd0);
    chk("ab_ct", ct, KAT_CT);
    ov = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    chk("ab_no_ov", 64'(ov), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
